// File: rtl/console_pkg.sv
// console_pkg -- shared types and constants for the VRAM text console.
//   state_t     : console FSM states (MARK only exists when
//                 VRAM_CONSOLE_CURSOR_EN is defined)
//   cur_cmd_t   : cursor update commands issued by the FSM to console_cursor
//   CH_*        : recognised control codes
//   DEF_COLS/DEF_ROWS : default text geometry
// Macro: VRAM_CONSOLE_CURSOR_EN (adds the MARK state).
package console_pkg;

  localparam int unsigned DEF_COLS = 30;
  localparam int unsigned DEF_ROWS = 25;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

`ifdef VRAM_CONSOLE_CURSOR_EN
  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, ROWCLR, MARK} state_t;
`else
  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, ROWCLR} state_t;
`endif

  typedef enum logic [2:0] {
    CUR_HOLD,  // no change
    CUR_INC,   // col+1, wrapping into a new row at COLS
    CUR_CR,    // col=0
    CUR_NL,    // col=0, advance row
    CUR_DEC,   // col-1
    CUR_HOME   // (0,0)
  } cur_cmd_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/console_cursor.sv
// console_cursor -- cursor and sweep position counters for vram_console.
// Keeps col/row plus row_base (= row*COLS, maintained incrementally) for the
// cursor, and an independent sweep position (sw_col, sw_base) used by the
// full-screen and single-row blanking sweeps, so the visible cursor does not
// move while a sweep runs.
// Ports:
//   clk_72m, reset (async, active-low)
//   cmd          in  cursor update command
//   sw_step      in  advance sweep position by one cell
//   sw_clr       in  return sweep position to cell 0 (wins over sw_step)
//   col,row      out cursor position
//   row_base     out address of column 0 of the cursor row
//   col_last     out cursor is in the last column
//   sw_col       out sweep column
//   sw_base      out address of column 0 of the sweep row
//   sw_col_last  out sweep is in the last column
//   sw_last      out sweep is at the last cell of the screen
module console_cursor
  import console_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
) (
  input  logic        clk_72m,
  input  logic        reset,
  input  cur_cmd_t    cmd,
  input  logic        sw_step,
  input  logic        sw_clr,
  output logic [4:0]  col,
  output logic [4:0]  row,
  output logic [11:0] row_base,
  output logic        col_last,
  output logic [4:0]  sw_col,
  output logic [11:0] sw_base,
  output logic        sw_col_last,
  output logic        sw_last
);

  localparam logic [4:0]  COL_MAX = 5'(COLS - 1);
  localparam logic [4:0]  ROW_MAX = 5'(ROWS - 1);
  localparam logic [11:0] STRIDE  = 12'(COLS);

  logic [4:0]  sw_row;
  logic [4:0]  row_nxt, sw_row_nxt;
  logic [11:0] base_nxt, sw_base_nxt;

  assign col_last    = (col == COL_MAX);
  assign sw_col_last = (sw_col == COL_MAX);
  assign sw_last     = sw_col_last && (sw_row == ROW_MAX);

  // Row advance wraps to the top of the screen; no scrolling.
  always_comb begin
    row_nxt     = (row == ROW_MAX) ? '0 : row + 5'd1;
    base_nxt    = (row == ROW_MAX) ? '0 : row_base + STRIDE;
    sw_row_nxt  = (sw_row == ROW_MAX) ? '0 : sw_row + 5'd1;
    sw_base_nxt = (sw_row == ROW_MAX) ? '0 : sw_base + STRIDE;
  end

  always_ff @(posedge clk_72m or negedge reset) begin
    if (!reset) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else begin
      case (cmd)
        CUR_INC: begin
          if (col_last) begin
            col      <= '0;
            row      <= row_nxt;
            row_base <= base_nxt;
          end else begin
            col <= col + 5'd1;
          end
        end
        CUR_CR: col <= '0;
        CUR_NL: begin
          col      <= '0;
          row      <= row_nxt;
          row_base <= base_nxt;
        end
        CUR_DEC: col <= col - 5'd1;
        CUR_HOME: begin
          col      <= '0;
          row      <= '0;
          row_base <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_72m or negedge reset) begin
    if (!reset) begin
      sw_col  <= '0;
      sw_row  <= '0;
      sw_base <= '0;
    end else if (sw_clr) begin
      sw_col  <= '0;
      sw_row  <= '0;
      sw_base <= '0;
    end else if (sw_step) begin
      if (sw_col_last) begin
        sw_col  <= '0;
        sw_row  <= sw_row_nxt;
        sw_base <= sw_base_nxt;
      end else begin
        sw_col <= sw_col + 5'd1;
      end
    end
  end

endmodule

// File: rtl/vram_console.sv
// vram_console -- character terminal writing into a text-mode VRAM.
// Accepts characters from the UART path, writes printable codes at the
// cursor, handles CR/LF/BS/FF, blanks new rows and sweeps the whole screen
// after reset or FF. Addresses are row_base+col (no multiplier).
// Ports:
//   clk_72m, reset (async, active-low)
//   char_data/char_valid  in   character and valid (held until accepted)
//   char_ready            out  high in IDLE only
//   ram_ce/addr/data      out  one-cycle VRAM write strobe, address, data
//   busy                  out  high in every state except IDLE
//   cursor_col/row        out  cursor position
// Macro: VRAM_CONSOLE_CURSOR_EN -- when defined, every sequence ending in
//   IDLE passes through MARK, which writes CURSOR at the cursor cell, and
//   cursor moves first blank the old cell.
module vram_console
  import console_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter logic [7:0]  BLANK  = 8'h20,
  parameter logic [7:0]  CURSOR = 8'h5F
) (
  input  logic        clk_72m,
  input  logic        reset,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  output logic        ram_ce,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        busy,
  output logic [4:0]  cursor_col,
  output logic [4:0]  cursor_row
);

  if (COLS < 1 || COLS > 32 || ROWS < 1 || ROWS > 32 ||
      COLS * ROWS > 4096 || CURSOR == BLANK) begin : g_bad_params
    $error("vram_console: unsupported COLS/ROWS/CURSOR setting");
  end

`ifdef VRAM_CONSOLE_CURSOR_EN
  localparam state_t DONE_ST   = MARK;
  localparam logic   ERASE_OLD = 1'b1;
`else
  localparam state_t DONE_ST   = IDLE;
  localparam logic   ERASE_OLD = 1'b0;
`endif

  state_t      state, state_nxt;
  logic [7:0]  char_q;
  logic        live;
  logic        we;
  logic [11:0] wa;
  logic [7:0]  wd;
  cur_cmd_t    cmd;
  logic        sw_step, sw_clr;
  logic [4:0]  col, row, sw_col;
  logic [11:0] row_base, sw_base;
  logic        col_last, sw_col_last, sw_last;

  console_cursor #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_cursor (
    .clk_72m    (clk_72m),
    .reset      (reset),
    .cmd        (cmd),
    .sw_step    (sw_step),
    .sw_clr     (sw_clr),
    .col        (col),
    .row        (row),
    .row_base   (row_base),
    .col_last   (col_last),
    .sw_col     (sw_col),
    .sw_base    (sw_base),
    .sw_col_last(sw_col_last),
    .sw_last    (sw_last)
  );

  // live holds the CLEAR sweep off for the first cycle after reset release,
  // so the combinational write strobe stays low throughout reset itself.
  always_ff @(posedge clk_72m or negedge reset) begin
    if (!reset) begin
      state  <= CLEAR;
      live   <= 1'b0;
      char_q <= '0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (state == IDLE && char_valid) char_q <= char_data;
    end
  end

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    wa        = row_base + {7'd0, col};
    wd        = BLANK;
    cmd       = CUR_HOLD;
    sw_step   = 1'b0;
    sw_clr    = 1'b0;
    case (state)
      CLEAR: begin
        if (live) begin
          we      = 1'b1;
          wa      = sw_base + {7'd0, sw_col};
          sw_step = 1'b1;
          if (sw_last) begin
            sw_clr    = 1'b1;
            state_nxt = DONE_ST;
          end
        end
      end
      IDLE: begin
        if (char_valid) state_nxt = WRITE;
      end
      WRITE: begin
        if (is_printable(char_q)) begin
          we        = 1'b1;
          wd        = char_q;
          cmd       = CUR_INC;
          state_nxt = col_last ? ROWCLR : DONE_ST;
        end else begin
          case (char_q)
            CH_CR: begin
              we        = ERASE_OLD;
              cmd       = CUR_CR;
              state_nxt = DONE_ST;
            end
            CH_LF: begin
              we        = ERASE_OLD;
              cmd       = CUR_NL;
              state_nxt = ROWCLR;
            end
            CH_BS: begin
              // With the cursor marker the old cell is blanked and MARK
              // lands on col-1; otherwise col-1 itself is blanked.
              if (col != '0) begin
                we  = 1'b1;
                wa  = ERASE_OLD ? row_base + {7'd0, col}
                                : row_base + {7'd0, col} - 12'd1;
                cmd = CUR_DEC;
              end
              state_nxt = DONE_ST;
            end
            CH_FF: begin
              cmd       = CUR_HOME;
              state_nxt = CLEAR;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
      ROWCLR: begin
        we      = 1'b1;
        wa      = row_base + {7'd0, sw_col};
        sw_step = 1'b1;
        if (sw_col_last) begin
          sw_clr    = 1'b1;
          state_nxt = DONE_ST;
        end
      end
`ifdef VRAM_CONSOLE_CURSOR_EN
      MARK: begin
        we        = 1'b1;
        wd        = CURSOR;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = CLEAR;
    endcase
  end

  assign ram_ce     = we;
  assign ram_addr   = we ? wa : '0;
  assign ram_data   = we ? wd : '0;
  assign char_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign cursor_col = col;
  assign cursor_row = row;

endmodule

// File: tb/tb_vram_console.sv
module tb_vram_console;

  localparam int COLS = 30;
  localparam int ROWS = 25;

  logic        clk_72m = 1'b0;
  logic        reset;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        ram_ce;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic        busy;
  logic [4:0]  cursor_col;
  logic [4:0]  cursor_row;

  always #5 clk_72m = ~clk_72m;

  vram_console #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) dut (
    .clk_72m   (clk_72m),
    .reset     (reset),
    .char_data (char_data),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .ram_ce    (ram_ce),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .busy      (busy),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row)
  );

  int ncmp = 0;
  int nbad = 0;
  int got_q[$];
  int exp_q[$];
  int m_col = 0;
  int m_row = 0;
  bit timed_out;
  bit first_ce;
  bit busy_err;

  // Reference terminal: each write encoded as addr*256+data.
  function automatic void model_clear();
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    for (int a = 0; a < COLS * ROWS; a++) exp_q.push_back(a * 256 + 32);
  endfunction

  function automatic void model_row_blank(input int r);
    for (int i = 0; i < COLS; i++) exp_q.push_back((r * COLS + i) * 256 + 32);
  endfunction

  function automatic void model_char(input logic [7:0] ch);
    exp_q.delete();
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      exp_q.push_back((m_row * COLS + m_col) * 256 + int'(ch));
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        model_row_blank(m_row);
      end
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      model_row_blank(m_row);
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_q.push_back((m_row * COLS + m_col) * 256 + 32);
      end
    end else if (ch == 8'h0C) begin
      model_clear();
    end
  endfunction

  // Record every write until char_ready returns (bounded).
  task automatic collect(input int budget);
    got_q.delete();
    timed_out = 1'b1;
    busy_err  = 1'b0;
    first_ce  = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk_72m);
      char_valid = 1'b0;
      if (n == 0) first_ce = ram_ce;
      if (busy !== ~char_ready) busy_err = 1'b1;
      if (char_ready === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      if (ram_ce === 1'b1) got_q.push_back(int'(ram_addr) * 256 + int'(ram_data));
    end
  endtask

  task automatic send_char(input logic [7:0] ch);
    int w;
    w = 0;
    while (char_ready !== 1'b1 && w < 2000) begin
      @(negedge clk_72m);
      w++;
    end
    char_data  = ch;
    char_valid = 1'b1;
    model_char(ch);
    collect(2000);
  endtask

  task automatic test_reset();
    int bad;
    reset      = 1'b0;
    char_valid = 1'b0;
    char_data  = '0;
    repeat (4) @(negedge clk_72m);
    ncmp++;
    if (ram_ce !== 1'b0 || ram_addr !== 12'd0 || ram_data !== 8'd0) begin
      nbad++;
      $display("FAIL reset_ram: ce=%b addr=%0d data=%h, required 0/0/00", ram_ce, ram_addr, ram_data);
    end
    ncmp++;
    if (char_ready !== 1'b0 || busy !== 1'b1) begin
      nbad++;
      $display("FAIL reset_flags: ready=%b busy=%b, required 0/1", char_ready, busy);
    end
    ncmp++;
    if (cursor_col !== 5'd0 || cursor_row !== 5'd0) begin
      nbad++;
      $display("FAIL reset_cursor: (%0d,%0d), required (0,0)", cursor_col, cursor_row);
    end
    reset = 1'b1;
    model_clear();
    collect(3000);
    ncmp++;
    if (timed_out || got_q.size() != 750 || got_q.size() != exp_q.size()) begin
      nbad++;
      $display("FAIL reset_sweep_count: %0d writes timeout=%0d, required 750", got_q.size(), timed_out);
    end
    ncmp++;
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] != exp_q[i]) begin bad = i; break; end
    if (bad >= 0) begin
      nbad++;
      $display("FAIL reset_sweep_data: write %0d addr=%0d data=%h, required addr=%0d data=%h",
               bad, got_q[bad] / 256, got_q[bad] % 256, exp_q[bad] / 256, exp_q[bad] % 256);
    end
  endtask

  task automatic test_single_char();
    send_char(8'h41);
    ncmp++;
    if (first_ce !== 1'b1 || got_q.size() != 1 || got_q.size() != exp_q.size()) begin
      nbad++;
      $display("FAIL char_A_write: first_ce=%b writes=%0d, required 1/1", first_ce, got_q.size());
    end else begin
      ncmp++;
      if (got_q[0] != 32'h41) begin
        nbad++;
        $display("FAIL char_A_data: addr=%0d data=%h, required addr=0 data=41", got_q[0] / 256, got_q[0] % 256);
      end
    end
    ncmp++;
    if (cursor_col !== 5'd1 || cursor_row !== 5'd0 || busy !== 1'b0) begin
      nbad++;
      $display("FAIL char_A_cursor: (%0d,%0d) busy=%b, required (1,0) busy=0", cursor_col, cursor_row, busy);
    end
  endtask

  task automatic test_full_row();
    int bad;
    send_char(8'h0D);
    ncmp++;
    if (timed_out || got_q.size() != 0 || cursor_col !== 5'd0) begin
      nbad++;
      $display("FAIL cr: writes=%0d col=%0d, required 0 writes col 0", got_q.size(), cursor_col);
    end
    for (int k = 0; k < COLS; k++) begin
      send_char(8'($urandom_range(32, 126)));
      ncmp++;
      if (timed_out || got_q.size() != exp_q.size() || first_ce !== 1'b1) begin
        nbad++;
        $display("FAIL row_fill_count: char %0d writes=%0d first_ce=%b, required %0d/1", k, got_q.size(), first_ce, exp_q.size());
      end
      bad = -1;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        if (got_q[i] != exp_q[i]) begin bad = i; break; end
      ncmp++;
      if (bad >= 0) begin
        nbad++;
        $display("FAIL row_fill_data: char %0d write %0d addr=%0d data=%h, required addr=%0d data=%h",
                 k, bad, got_q[bad] / 256, got_q[bad] % 256, exp_q[bad] / 256, exp_q[bad] % 256);
      end
    end
    ncmp++;
    if (got_q.size() != 31 || got_q[0] / 256 != 29 || got_q[30] / 256 != 59) begin
      nbad++;
      $display("FAIL row_wrap_span: %0d writes, required 31 (addr 29 then 30..59)", got_q.size());
    end
    ncmp++;
    if (cursor_col !== 5'd0 || cursor_row !== 5'd1) begin
      nbad++;
      $display("FAIL row_wrap_cursor: (%0d,%0d), required (0,1)", cursor_col, cursor_row);
    end
  endtask

  task automatic test_lf_wrap();
    int bad;
    repeat (23) send_char(8'h0A);
    repeat (5) send_char(8'($urandom_range(32, 126)));
    ncmp++;
    if (cursor_col !== 5'd5 || cursor_row !== 5'd24) begin
      nbad++;
      $display("FAIL lf_setup_cursor: (%0d,%0d), required (5,24)", cursor_col, cursor_row);
    end
    send_char(8'h0A);
    ncmp++;
    if (timed_out || got_q.size() != 30 || got_q.size() != exp_q.size()) begin
      nbad++;
      $display("FAIL lf_wrap_count: writes=%0d timeout=%0d, required 30", got_q.size(), timed_out);
    end
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] != exp_q[i]) begin bad = i; break; end
    ncmp++;
    if (bad >= 0) begin
      nbad++;
      $display("FAIL lf_wrap_data: write %0d addr=%0d data=%h, required addr=%0d data=%h",
               bad, got_q[bad] / 256, got_q[bad] % 256, exp_q[bad] / 256, exp_q[bad] % 256);
    end
    ncmp++;
    if (cursor_col !== 5'd0 || cursor_row !== 5'd0) begin
      nbad++;
      $display("FAIL lf_wrap_cursor: (%0d,%0d), required (0,0)", cursor_col, cursor_row);
    end
  endtask

  task automatic test_backspace();
    repeat (2) send_char(8'h0A);
    repeat (3) send_char(8'($urandom_range(32, 126)));
    send_char(8'h08);
    ncmp++;
    if (timed_out || got_q.size() != 1 || got_q[0] != 62 * 256 + 32) begin
      nbad++;
      $display("FAIL bs_write: writes=%0d first=%0d/%h, required 1 write addr=62 data=20",
               got_q.size(), got_q.size() ? got_q[0] / 256 : -1, got_q.size() ? got_q[0] % 256 : 0);
    end
    ncmp++;
    if (cursor_col !== 5'd2 || cursor_row !== 5'd2) begin
      nbad++;
      $display("FAIL bs_cursor: (%0d,%0d), required (2,2)", cursor_col, cursor_row);
    end
    send_char(8'h0D);
    send_char(8'h08);
    ncmp++;
    if (timed_out || got_q.size() != 0) begin
      nbad++;
      $display("FAIL bs_col0_write: writes=%0d timeout=%0d, required 0", got_q.size(), timed_out);
    end
    ncmp++;
    if (cursor_col !== 5'd0 || cursor_row !== 5'd2) begin
      nbad++;
      $display("FAIL bs_col0_cursor: (%0d,%0d), required (0,2)", cursor_col, cursor_row);
    end
  endtask

  task automatic test_random();
    int bad;
    int r;
    logic [7:0] ch;
    for (int k = 0; k < 160; k++) begin
      r = $urandom_range(0, 99);
      if (r < 68)      ch = 8'($urandom_range(32, 126));
      else if (r < 76) ch = 8'h0D;
      else if (r < 84) ch = 8'h0A;
      else if (r < 93) ch = 8'h08;
      else if (r < 99) begin
        ch = 8'($urandom_range(0, 255));
        if ((ch >= 8'h20 && ch <= 8'h7E) || ch == 8'h0D || ch == 8'h0A || ch == 8'h08 || ch == 8'h0C)
          ch = 8'h7F;
      end else         ch = 8'h0C;
      send_char(ch);
      ncmp++;
      if (timed_out || got_q.size() != exp_q.size() || busy_err) begin
        nbad++;
        $display("FAIL rand_count: char %0d code %h writes=%0d timeout=%0d busy_err=%0d, required %0d writes",
                 k, ch, got_q.size(), timed_out, busy_err, exp_q.size());
      end
      bad = -1;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        if (got_q[i] != exp_q[i]) begin bad = i; break; end
      ncmp++;
      if (bad >= 0) begin
        nbad++;
        $display("FAIL rand_data: char %0d code %h write %0d addr=%0d data=%h, required addr=%0d data=%h",
                 k, ch, bad, got_q[bad] / 256, got_q[bad] % 256, exp_q[bad] / 256, exp_q[bad] % 256);
      end
      ncmp++;
      if (cursor_col !== 5'(m_col) || cursor_row !== 5'(m_row) ||
          ((ch >= 8'h20 && ch <= 8'h7E) && first_ce !== 1'b1)) begin
        nbad++;
        $display("FAIL rand_cursor: char %0d code %h cursor (%0d,%0d) first_ce=%b, required (%0d,%0d)",
                 k, ch, cursor_col, cursor_row, first_ce, m_col, m_row);
      end
    end
  endtask

  task automatic test_reset_mid_ff();
    int bad;
    bit found;
    int w;
    w = 0;
    while (char_ready !== 1'b1 && w < 2000) begin
      @(negedge clk_72m);
      w++;
    end
    char_data  = 8'h0C;
    char_valid = 1'b1;
    found      = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk_72m);
      char_valid = 1'b0;
      if (ram_ce === 1'b1 && ram_addr == 12'd400) begin
        found = 1'b1;
        break;
      end
    end
    ncmp++;
    if (!found) begin
      nbad++;
      $display("FAIL ff_reach_400: cell 400 write seen=%0d, required 1", found);
    end
    reset = 1'b0;
    #1;
    ncmp++;
    if (ram_ce !== 1'b0 || busy !== 1'b1 || char_ready !== 1'b0) begin
      nbad++;
      $display("FAIL abort_outputs: ce=%b busy=%b ready=%b, required 0/1/0", ram_ce, busy, char_ready);
    end
    ncmp++;
    if (cursor_col !== 5'd0 || cursor_row !== 5'd0 || ram_addr !== 12'd0) begin
      nbad++;
      $display("FAIL abort_state: cursor (%0d,%0d) addr=%0d, required (0,0) addr=0", cursor_col, cursor_row, ram_addr);
    end
    repeat (2) @(negedge clk_72m);
    reset = 1'b1;
    model_clear();
    collect(3000);
    ncmp++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      nbad++;
      $display("FAIL restart_count: writes=%0d timeout=%0d, required %0d", got_q.size(), timed_out, exp_q.size());
    end
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] != exp_q[i]) begin bad = i; break; end
    ncmp++;
    if (bad >= 0) begin
      nbad++;
      $display("FAIL restart_data: write %0d addr=%0d data=%h, required addr=%0d data=%h",
               bad, got_q[bad] / 256, got_q[bad] % 256, exp_q[bad] / 256, exp_q[bad] % 256);
    end
    ncmp++;
    if (cursor_col !== 5'd0 || cursor_row !== 5'd0) begin
      nbad++;
      $display("FAIL restart_cursor: (%0d,%0d), required (0,0)", cursor_col, cursor_row);
    end
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_full_row();
    test_lf_wrap();
    test_backspace();
    test_random();
    test_reset_mid_ff();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/vram_console.md
VRAM_CONSOLE -- requirements
Module: vram_console

Interface
REQ-001 Parameter COLS, 30, characters per text row.
REQ-002 Parameter ROWS, 25, text rows; COLS*ROWS SHALL be at most 4096.
REQ-003 Parameter BLANK, 8'h20, fill character used for clears and erases.
REQ-004 Parameter CURSOR, 8'h5F, cursor marker character.
REQ-005 clk_72m  in  1  system clock; reset  in  1  asynchronous, active-low.
REQ-006 char_data  in  8  character code from the UART receive path.
REQ-007 char_valid  in  1  char_data valid; held by the source until accepted.
REQ-008 char_ready  out  1  block can accept a character this cycle.
REQ-009 ram_ce  out  1  VRAM write strobe, one cycle per cell.
REQ-010 ram_addr  out  12  VRAM cell address, row*COLS+col.
REQ-011 ram_data  out  8  character written to the cell.
REQ-012 busy  out  1  clear sweep or sequence in progress.
REQ-013 cursor_col  out  5  and cursor_row  out  5: current cursor position.

Function
REQ-014 States SHALL be CLEAR, IDLE, WRITE, ROWCLR and MARK.
REQ-015 Handshake: a transfer occurs when char_valid and char_ready are both high on a clock edge; char_ready SHALL be high only in IDLE.
REQ-016 Printable code (0x20..0x7E): the cycle after acceptance, the block SHALL drive ram_ce=1 with ram_addr at the cursor and ram_data=char_data, then advance col by one.
REQ-017 When col reaches COLS, col SHALL be set to 0, row SHALL advance, and the block SHALL enter ROWCLR.
REQ-018 Row advance past ROWS-1 SHALL wrap to row 0; there is no scrolling.
REQ-019 ROWCLR SHALL write BLANK to the COLS cells of the new row, in ascending address order, one per cycle, then go to IDLE.
REQ-020 0x0D (CR) SHALL set col=0 with no VRAM write.
REQ-021 0x0A (LF) SHALL set col=0, advance row and enter ROWCLR.
REQ-022 0x08 (BS) at col>0 SHALL decrement col and write BLANK there; at col=0 it SHALL do nothing.
REQ-023 0x0C (FF) SHALL enter CLEAR and home the cursor.
REQ-024 All other codes SHALL be discarded, with a one-cycle return to IDLE.
REQ-025 CLEAR SHALL write BLANK to addresses 0..COLS*ROWS-1, ascending, one per cycle, then go to IDLE with cursor (0,0).
REQ-026 Addresses SHALL be formed as row_base+col, where row_base is an incremental register (+COLS, wrapping to 0); no multiplier.
REQ-027 busy SHALL be high in every state except IDLE.
REQ-028 ram_ce SHALL be low in every cycle without a write.

Reset
REQ-029 While reset is low: ram_ce=0, ram_addr=0, ram_data=0, char_ready=0, busy=1, cursor (0,0), state CLEAR.
REQ-030 Deassertion of reset SHALL start a full CLEAR sweep from address 0.
REQ-031 Reset asserted mid-sweep or mid-sequence SHALL abort it immediately; no partial state SHALL survive.

Configuration
REQ-032 Macro VRAM_CONSOLE_CURSOR_EN.
- Defined: after every sequence that ends in IDLE (including CLEAR), the block SHALL pass through MARK and write CURSOR at the new cursor cell, adding one cycle. Before the cursor moves, the old cursor cell SHALL be overwritten by the character write or by BLANK.
- Undefined: MARK SHALL be absent and no cursor writes SHALL occur.

Structure
REQ-033 Package console_pkg SHALL hold the state enum, the control-code constants (CR, LF, BS, FF) and the default COLS/ROWS.
REQ-034 Sub-module console_cursor SHALL hold the col/row/row_base counters with wrap logic; the FSM and VRAM port stay in vram_console.

Verification
REQ-035 Release reset -> 750 ram_ce pulses, addresses 0..749, data 0x20, then char_ready=1.
REQ-036 Send 'A' (0x41) at (0,0) -> ram_ce on the next cycle with addr 0, data 0x41; cursor_col=1.
REQ-037 Send 30 printable characters from col 0 -> last written at addr 29, then 30 BLANK writes at addr 30..59, cursor (0,1).
REQ-038 Cursor at (5,24), send LF -> row wraps to 0; BLANK written at addr 0..29; cursor (0,0).
REQ-039 Cursor (3,2), send BS -> single write addr 62, data 0x20; cursor (2,2). Cursor (0,2), send BS -> no write.
REQ-040 Pull reset low at cell 400 of a FF sweep -> ram_ce=0 immediately; after release, a full sweep restarts at addr 0.
